// File: rtl/sha256_msg_sched_pkg.sv
// sha256_msg_sched_pkg: shared SHA-256 sigma helpers and schedule FSM types.
package sha256_msg_sched_pkg;
  localparam int SCHED_BLOCK_WORDS = 16;
  typedef enum logic {LOAD, STREAM} sched_state_e;
  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] shr(input logic [31:0] x, input int unsigned n);
    return x >> n;
  endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ shr(x, 3);
  endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ shr(x, 10);
  endfunction
endpackage

// File: rtl/sha256_sched_window.sv
// sha256_sched_window: 16-word shift window with the next schedule word adder tree.
module sha256_sched_window
  import sha256_msg_sched_pkg::*;
(
  input  logic        clk,
  input  logic        n_reset_i,
  input  logic        shift,
  input  logic [31:0] in_word,
  output logic [31:0] oldest,
  output logic [31:0] next_word
);
  logic [31:0] win [SCHED_BLOCK_WORDS];
  always_ff @(posedge clk or negedge n_reset_i)
    if (!n_reset_i)
      for (int i = 0; i < SCHED_BLOCK_WORDS; i++) win[i] <= '0;
    else if (shift) begin
      for (int i = 0; i < SCHED_BLOCK_WORDS - 1; i++) win[i] <= win[i+1];
      win[SCHED_BLOCK_WORDS-1] <= in_word;
    end
  assign oldest = win[0];
  assign next_word = ssig1(win[14]) + win[9] + ssig0(win[1]) + win[0];
endmodule

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: loads a 16-word block and streams the expanded SHA-256 schedule.
module sha256_msg_sched
  import sha256_msg_sched_pkg::*;
#(
  parameter int ROUNDS = 64,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              n_reset_i,
  input  logic              flush_i,
  input  logic              load_valid_i,
  input  logic [WORD_W-1:0] load_word_i,
  output logic              load_ready_o,
  output logic              w_valid_o,
  output logic [WORD_W-1:0] w_word_o,
  output logic [5:0]        w_index_o,
  input  logic              w_ready_i,
  output logic              busy_o
);
  if (WORD_W != 32) begin : g_bad_word_w
    $error("sha256_msg_sched: WORD_W must be 32");
  end
  if (ROUNDS < 16 || ROUNDS > 64) begin : g_bad_rounds
    $error("sha256_msg_sched: ROUNDS must be 16..64");
  end
  sched_state_e state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [5:0] t, t_nx;
  logic load_hs, rd_hs, done;
  logic [31:0] next_word;
  always_comb begin
    load_hs = state == LOAD && load_valid_i && !flush_i;
    rd_hs = state == STREAM && w_ready_i && !flush_i;
    done = rd_hs && t == 6'(ROUNDS - 1);
    state_nx = flush_i || done ? LOAD : load_hs && cnt == 4'd15 ? STREAM : state;
    cnt_nx = flush_i || done ? '0 : load_hs ? cnt + 4'd1 : cnt;
    t_nx = flush_i || done ? '0 : rd_hs ? t + 6'd1 : t;
  end
  always_ff @(posedge clk or negedge n_reset_i)
    if (!n_reset_i) begin
      state <= LOAD;
      cnt <= '0;
      t <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      t <= t_nx;
    end
  sha256_sched_window u_window (
    .clk      (clk),
    .n_reset_i(n_reset_i),
    .shift    (load_hs || rd_hs),
    .in_word  (state == LOAD ? load_word_i : next_word),
    .oldest   (w_word_o),
    .next_word(next_word)
  );
  assign load_ready_o = state == LOAD;
  assign w_valid_o = state == STREAM;
  assign w_index_o = t;
  assign busy_o = state != LOAD || cnt != '0;
endmodule

// File: tb/tb_sha256_msg_sched.sv
// tb_sha256_msg_sched: directed bench with a behavioural schedule model and per-cycle compare.
module tb_sha256_msg_sched;
  logic clk = 0;
  always #5 clk = ~clk;
  logic n_reset, flush, lv, rdy, lr, wv, busy;
  logic [31:0] lw, ww;
  logic [5:0] wi;
  logic flush16, lv16, rdy16, lr16, wv16, busy16;
  logic [31:0] lw16, ww16;
  logic [5:0] wi16;
  int checks = 0, failures = 0;

  sha256_msg_sched dut (
    .clk(clk), .n_reset_i(n_reset), .flush_i(flush), .load_valid_i(lv), .load_word_i(lw),
    .load_ready_o(lr), .w_valid_o(wv), .w_word_o(ww), .w_index_o(wi), .w_ready_i(rdy), .busy_o(busy)
  );
  sha256_msg_sched #(.ROUNDS(16)) dut16 (
    .clk(clk), .n_reset_i(n_reset), .flush_i(flush16), .load_valid_i(lv16), .load_word_i(lw16),
    .load_ready_o(lr16), .w_valid_o(wv16), .w_word_o(ww16), .w_index_o(wi16), .w_ready_i(rdy16), .busy_o(busy16)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction
  function automatic logic [31:0] s0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] s1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  // model: the block captured from accepted loads, and the full schedule derived from it
  logic ms;
  int mlc, mt;
  logic [31:0] mb [16];
  logic [31:0] sched [64];
  always_comb begin
    for (int k = 0; k < 16; k++) sched[k] = mb[k];
    for (int k = 16; k < 64; k++) sched[k] = s1(sched[k-2]) + sched[k-7] + s0(sched[k-15]) + sched[k-16];
  end
  always @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      ms <= 0; mlc <= 0; mt <= 0;
    end else if (flush) begin
      ms <= 0; mlc <= 0; mt <= 0;
    end else if (!ms) begin
      if (lv) begin
        mb[mlc] <= lw;
        if (mlc == 15) begin ms <= 1; mlc <= 0; end
        else mlc <= mlc + 1;
      end
    end else if (rdy) begin
      if (mt == 63) begin ms <= 0; mt <= 0; end
      else mt <= mt + 1;
    end

  always @(negedge clk)
    if (n_reset) begin
      chk("load_ready", 32'(lr), 32'(!ms));
      chk("w_valid", 32'(wv), 32'(ms));
      chk("busy", 32'(busy), 32'(ms || mlc != 0));
      chk("w_index", 32'(wi), 32'(mt));
      if (ms) chk("w_word", ww, sched[mt]);
    end

  logic [31:0] blocks [2][16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic load_block(input int b);
    for (int i = 0; i < 16; i++) begin
      lv = 1; lw = blocks[b][i];
      step();
    end
    lv = 0;
  endtask
  task automatic stream(input bit rnd);
    int n = 0;
    while (ms && n < 1000) begin
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      n++;
    end
    rdy = 0;
    if (ms) begin
      checks++; failures++;
      $display("FAIL stream_timeout actual=%0d cycles required=end of block", n);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      blocks[0][i] = 32'h0;
      blocks[1][i] = (32'(i) + 32'd1) * 32'h9e3779b9 ^ 32'h5a5a0000;
    end
    blocks[0][0] = 32'h61626380;
    blocks[0][15] = 32'h00000018;
    n_reset = 0; flush = 0; lv = 0; rdy = 0; lw = 0;
    flush16 = 0; lv16 = 0; rdy16 = 0; lw16 = 0;
    #12;
    chk("rst_load_ready", 32'(lr), 32'd1);
    chk("rst_w_valid", 32'(wv), 32'd0);
    chk("rst_w_word", ww, 32'd0);
    chk("rst_w_index", 32'(wi), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    step();
    n_reset = 1;
    step();
    // abc block, full throughput
    load_block(0);
    chk("w16_literal", sched[16], 32'h61626380);
    chk("w17_literal", sched[17], 32'h000F0000);
    chk("w18_literal", sched[18], 32'h7DA86405);
    chk("w0_latency_valid", 32'(wv), 32'd1);
    chk("w0_latency_word", ww, 32'h61626380);
    stream(0);
    chk("after_stream_load_ready", 32'(lr), 32'd1);
    // same block under random backpressure
    load_block(0);
    stream(1);
    // flush at t=20
    load_block(0);
    rdy = 1;
    for (int n = 0; n < 100 && mt != 20; n++) step();
    chk("flush_at_t", 32'(wi), 32'd20);
    flush = 1;
    step();
    flush = 0; rdy = 0;
    chk("flush_w_valid", 32'(wv), 32'd0);
    chk("flush_load_ready", 32'(lr), 32'd1);
    chk("flush_w_index", 32'(wi), 32'd0);
    chk("flush_busy", 32'(busy), 32'd0);
    load_block(1);
    stream(0);
    // async reset after 7 load words
    for (int i = 0; i < 7; i++) begin
      lv = 1; lw = blocks[1][i];
      step();
    end
    lv = 0;
    chk("partial_busy", 32'(busy), 32'd1);
    #3 n_reset = 0;
    #1;
    chk("async_load_ready", 32'(lr), 32'd1);
    chk("async_w_valid", 32'(wv), 32'd0);
    chk("async_w_word", ww, 32'd0);
    chk("async_w_index", 32'(wi), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    step();
    n_reset = 1;
    step();
    load_block(0);
    stream(1);
    // back-to-back blocks with load_valid held high
    load_block(1);
    lv = 1; rdy = 1;
    for (int n = 0; n < 100 && ms; n++) begin
      lw = blocks[0][0];
      step();
    end
    for (int i = 0; i < 16; i++) begin
      lw = blocks[0][i];
      step();
    end
    lv = 0; rdy = 0;
    chk("b2b_w_valid", 32'(wv), 32'd1);
    chk("b2b_w0", ww, blocks[0][0]);
    stream(0);
    // ROUNDS=16 instance emits the block unchanged
    for (int i = 0; i < 16; i++) begin
      lv16 = 1; lw16 = blocks[1][i];
      step();
    end
    lv16 = 0; rdy16 = 1;
    for (int k = 0; k < 16; k++) begin
      chk("r16_valid", 32'(wv16), 32'd1);
      chk("r16_index", 32'(wi16), 32'(k));
      chk("r16_word", ww16, blocks[1][k]);
      step();
    end
    rdy16 = 0;
    chk("r16_done_valid", 32'(wv16), 32'd0);
    chk("r16_done_load_ready", 32'(lr16), 32'd1);
    chk("r16_done_busy", 32'(busy16), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sha256_msg_sched.md
Name: sha256_msg_sched

Overview:
Multi-cycle SHA-256 message-schedule expander that feeds the core's SHA round datapath. It accepts one 512-bit block as 16 big-endian 32-bit words over a valid/ready load port. It then streams W[0..ROUNDS-1] out over a valid/ready read port. Expansion uses the small-sigma functions (the same ones the ALU's SSZ/SSO ops compute), so software can hand schedule generation to this unit and use the ALU only for the round compression.

Parameters:
ROUNDS, 64, number of schedule words emitted per block; legal range 16..64.
WORD_W, 32, word width; fixed at 32, with elaboration-time assertion.

Ports:
clk  in  1  core clock
n_reset_i  in  1  asynchronous active-low reset
flush_i  in  1  synchronous abort; returns the unit to LOAD
load_valid_i  in  1  load word valid
load_word_i  in  32  message word, in order W0 first
load_ready_o  out  1  unit accepts a load word this cycle
w_valid_o  out  1  schedule word valid
w_word_o  out  32  schedule word W[t]
w_index_o  out  6  t of the presented word
w_ready_i  in  1  consumer accepts W[t] this cycle
busy_o  out  1  high in any state other than LOAD-with-count-0

Behaviour:
- One clock, clk. Reset is asynchronous, active-low on n_reset_i. It clears state to LOAD, load count to 0, t to 0, and all 16 window registers to 0.
- Reset output values: load_ready_o=1, w_valid_o=0, w_word_o=0, w_index_o=0, busy_o=0.
- Storage is a 16-entry shift window win[0..15]. win[0] is the oldest word.
- A shift moves win[i]<=win[i+1] and writes win[15]<=in_word.
- State LOAD:
  - load_ready_o=1 and w_valid_o=0.
  - Each load handshake (load_valid_i & load_ready_o) shifts in load_word_i and increments the load count.
  - On the 16th handshake the FSM goes to STREAM with t=0.
- State STREAM:
  - load_ready_o=0 and w_valid_o=1.
  - w_word_o=win[0] and w_index_o=t; both are direct register outputs.
  - On a read handshake (w_valid_o & w_ready_i), the window shifts in new=ssig1(win[14])+win[9]+ssig0(win[1])+win[0], with mod-2^32 addition.
  - ssig0(x)=ROTR7^ROTR18^SHR3. ssig1(x)=ROTR17^ROTR19^SHR10.
  - new is needed only while t<=ROUNDS-17; later shifts insert don't-care values, which are driven as computed.
  - Each handshake increments t.
  - The handshake at t=ROUNDS-1 goes to LOAD and clears t and the load count.
- Latency: W0 is valid in the cycle after the 16th load handshake. Each subsequent word follows 1 cycle after the prior handshake, giving full throughput of 1 word/cycle when w_ready_i=1.
- Backpressure: while w_valid_o=1 and w_ready_i=0, w_word_o and w_index_o must hold stable.
- flush_i has priority over any same-cycle load or read handshake; that handshake is not counted.
  - flush_i sets state LOAD, load count 0, t 0.
  - Window contents are not cleared.
  - While flush_i is high, load_ready_o and w_valid_o keep their state-derived values, but the handshake has no effect.
- Partial load (count 1..15) keeps busy_o=1 and simply waits; there is no timeout.
- A reset asserted mid-load or mid-stream aborts immediately to the reset values above.
- Load and read handshakes can never occur in the same cycle, because the states are exclusive.

Decomposition:
- Shared package: ROTR/SHR helpers, ssig0/ssig1 functions, the sched_state_e enum {LOAD, STREAM}, and a localparam SCHED_BLOCK_WORDS=16.
- The ALU's SSZ/SSO paths should reuse the same functions.
- One natural sub-module, sha256_sched_window: the 16x32 shift window plus the next-word adder tree. The FSM, counters and handshakes stay in the top.

Test Plan:
1. "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018) with w_ready_i=1 -> expected outputs:
   - W0..W15 echoed in order.
   - W16=0x61626380, W17=0x000F0000, W18=0x7DA86405.
   - 64 words total, then load_ready_o=1.
   - W0 appears exactly 1 cycle after the 16th load.
2. Same block with w_ready_i toggled pseudo-randomly (about 50% duty) -> identical word sequence; w_word_o and w_index_o stable whenever stalled.
3. flush_i asserted at t=20 together with w_ready_i=1 -> next cycle state LOAD, w_valid_o=0, load_ready_o=1; a fresh block reload streams correctly from W0.
4. n_reset_i dropped asynchronously after 7 load words -> outputs at reset values immediately, without waiting for a clock edge; a full 16-word reload then produces the correct schedule.
5. ROUNDS=16 -> exactly 16 words emitted, equal to the input block, with no expansion.
6. Back-to-back blocks, with load_valid_i held high and the next block's words queued -> the second block loads starting in the cycle after the W63 handshake; load_word_i is never accepted during STREAM.
